// File: rtl/prime_pkg.sv
// Shared constants for the prime scanner: FSM state encoding and default widths.
package prime_pkg;
   localparam int W_DEF     = 8;
   localparam int DEPTH_DEF = 4;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SCAN  = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_FIN   = 2'd3;
endpackage

// File: rtl/prime.sv
// Combinational primality checker: trial division by every d with d*d <= n.
module prime #(
   parameter int W = 8
) (
   input  logic [W-1:0] i_n,
   output logic         o_is_prime
);
   // Largest divisor worth trying: sqrt(2^W - 1) < 2^ceil(W/2).
   localparam int DMAX = (1 << ((W + 1) / 2)) - 1;

   int w_v;
   assign w_v = int'(i_n);

   always_comb begin
      o_is_prime = (w_v >= 2);
      for (int d = 2; d <= DMAX; d++) begin
         if ((d * d <= w_v) && (w_v % d == 0)) begin
            o_is_prime = 1'b0;
         end
      end
   end
endmodule

// File: rtl/prime_fifo.sv
// Output buffer for found primes: circular pointers plus an occupancy counter.
module prime_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       i_push,
   input  logic [W-1:0]               i_data,
   input  logic                       i_pop,
   output logic                       o_valid,
   output logic [W-1:0]               o_data,
   output logic [$clog2(DEPTH):0]     o_count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          w_do_push;
   logic          w_do_pop;

   assign w_do_push = i_push && (r_count != FULL);
   assign w_do_pop  = i_pop && (r_count != '0);

   // Gate the head with occupancy so out_data reads 0 whenever nothing is held.
   assign o_valid = (r_count != '0);
   assign o_data  = o_valid ? r_mem[r_rd_ptr] : '0;
   assign o_count = r_count;

   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end
endmodule

// File: rtl/prime_scanner.sv
// Walks cur from lo to hi, pushing each prime into a small FIFO drained by a
// valid/ready consumer.
module prime_scanner
   import prime_pkg::*;
#(
   parameter int W     = W_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [W-1:0] lo,
   input  logic [W-1:0] hi,
   output logic         busy,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic         done,
   output logic [W-1:0] prime_cnt,
   output logic [1:0]   dbg_state
);
   // Handshake: the head transfers on a rising edge where out_valid and
   // out_ready are both high; while out_valid=1 and out_ready=0 the head holds.
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

   logic [1:0]   r_state;
   logic [W-1:0] r_cur;
   logic [W-1:0] r_hi;
   logic [W-1:0] r_cnt;
   logic         w_is_prime;
   logic         w_room;
   logic         w_push;
   logic         w_pop;
   logic [AW:0]  w_count;

   prime #(.W(W)) u_prime (
      .i_n        (r_cur),
      .o_is_prime (w_is_prime)
   );

   prime_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_data  (r_cur),
      .i_pop   (w_pop),
      .o_valid (out_valid),
      .o_data  (out_data),
      .o_count (w_count)
   );

   // Room is judged on registered occupancy, so a same-cycle pop never unstalls.
   assign w_room    = (w_count != FULL);
   assign w_push    = (r_state == ST_SCAN) && w_room && w_is_prime;
   assign w_pop     = out_valid && out_ready;
   assign busy      = (r_state != ST_IDLE);
   assign done      = (r_state == ST_FIN);
   assign prime_cnt = r_cnt;
   assign dbg_state = r_state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_cur   <= '0;
         r_hi    <= '0;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_cnt <= '0;
                  if (lo <= hi) begin
                     r_cur   <= lo;
                     r_hi    <= hi;
                     r_state <= ST_SCAN;
                  end else begin
                     r_state <= ST_FIN;
                  end
               end
            end
            ST_SCAN: begin
               if (w_room) begin
                  if (w_push) r_cnt <= r_cnt + 1'b1;
                  // Stopping at hi before incrementing keeps cur from wrapping.
                  if (r_cur == r_hi) r_state <= ST_DRAIN;
                  else               r_cur   <= r_cur + 1'b1;
               end
            end
            ST_DRAIN: begin
               if (w_count == '0) r_state <= ST_FIN;
            end
            ST_FIN: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_prime_scanner.sv
// Scoreboard bench for prime_scanner: a trial-division reference model fills
// exp_q at each start; a monitor pops and compares every accepted output.
module tb_prime_scanner;
   import prime_pkg::*;

   localparam int W     = 8;
   localparam int DEPTH = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] lo = '0;
   logic [W-1:0] hi = '0;
   logic         out_ready = 1'b0;
   logic         busy;
   logic         out_valid;
   logic [W-1:0] out_data;
   logic         done;
   logic [W-1:0] prime_cnt;
   logic [1:0]   dbg_state;

   prime_scanner #(.W(W), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .lo        (lo),
      .hi        (hi),
      .busy      (busy),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .done      (done),
      .prime_cnt (prime_cnt),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard state ----------------
   int           checks = 0;
   int           errors = 0;
   logic [W-1:0] exp_q[$];
   int           exp_cnt = 0;
   int           done_cnt = 0;
   int           done_base = 0;
   int           ready_pct = 100;
   logic         hold_pending = 1'b0;
   logic [W-1:0] held_data = '0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: plain trial division over every smaller divisor.
   function automatic bit ref_is_prime(input int n);
      if (n < 2) return 1'b0;
      for (int d = 2; d < n; d++) begin
         if (n % d == 0) return 1'b0;
      end
      return 1'b1;
   endfunction

   // ---------------- monitor ----------------
   initial begin
      forever begin
         @(negedge clk);
         if (done) done_cnt++;
         if (rst_n && out_valid) begin
            if (hold_pending) check("hold_data", int'(out_data), int'(held_data));
            if (out_ready) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_output", int'(out_data), -1);
               end else begin
                  check("out_data", int'(out_data), int'(exp_q.pop_front()));
               end
               hold_pending = 1'b0;
            end else begin
               hold_pending = 1'b1;
               held_data    = out_data;
            end
         end else begin
            if (rst_n && hold_pending) check("hold_valid", int'(out_valid), 1);
            hold_pending = 1'b0;
         end
      end
   end

   // ---------------- drivers ----------------
   initial begin
      forever begin
         @(posedge clk);
         #1;
         out_ready = ($urandom_range(0, 99) < ready_pct);
      end
   end

   task automatic pulse_start(input int lo_v, input int hi_v);
      @(posedge clk);
      #1;
      lo    = W'(lo_v);
      hi    = W'(hi_v);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic begin_scan(input int lo_v, input int hi_v);
      exp_cnt = 0;
      for (int n = lo_v; n <= hi_v; n++) begin
         if (ref_is_prime(n)) begin
            exp_q.push_back(W'(n));
            exp_cnt++;
         end
      end
      done_base = done_cnt;
      pulse_start(lo_v, hi_v);
   endtask

   task automatic wait_done(input string name, input int budget);
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      check({name, "_done_seen"}, int'(seen), 1);
      if (seen) check({name, "_prime_cnt"}, int'(prime_cnt), exp_cnt);
      @(negedge clk);
      check({name, "_done_one_cycle"}, int'(done), 0);
      check({name, "_idle_busy"}, int'(busy), 0);
      check({name, "_queue_empty"}, exp_q.size(), 0);
      check({name, "_done_pulses"}, done_cnt - done_base, 1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int r_lo;
      int r_hi;
      bit reached;

      // Reset values while rst_n is low.
      repeat (3) @(negedge clk);
      check("rst_busy", int'(busy), 0);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_out_data", int'(out_data), 0);
      check("rst_done", int'(done), 0);
      check("rst_prime_cnt", int'(prime_cnt), 0);
      check("rst_state", int'(dbg_state), int'(ST_IDLE));
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Full-rate consumer, small range.
      ready_pct = 100;
      begin_scan(0, 20);
      wait_done("scan_0_20", 200);

      // Consumer stalled: buffer fills with the first DEPTH primes and scanning freezes.
      ready_pct = 0;
      begin_scan(0, 30);
      repeat (40) @(negedge clk);
      check("stall_valid", int'(out_valid), 1);
      check("stall_head", int'(out_data), 2);
      check("stall_cnt", int'(prime_cnt), 4);
      check("stall_state", int'(dbg_state), int'(ST_SCAN));
      ready_pct = 100;
      wait_done("scan_0_30", 300);

      // Top of range: must terminate rather than wrap.
      begin_scan(250, 255);
      wait_done("scan_250_255", 100);

      // Single non-prime candidate.
      begin_scan(1, 1);
      wait_done("scan_1_1", 8);

      // Inverted bounds: FIN right after the accepted start.
      begin_scan(9, 3);
      check("lo_gt_hi_done_now", int'(done), 1);
      wait_done("scan_9_3", 4);

      // Asynchronous reset with three entries buffered.
      ready_pct = 0;
      begin_scan(0, 30);
      reached = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (prime_cnt == W'(3)) begin
            reached = 1'b1;
            break;
         end
      end
      check("rst_mid_reached", int'(reached), 1);
      check("rst_mid_valid_before", int'(out_valid), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_mid_valid", int'(out_valid), 0);
      check("rst_mid_busy", int'(busy), 0);
      check("rst_mid_cnt", int'(prime_cnt), 0);
      check("rst_mid_data", int'(out_data), 0);
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("post_rst_idle", int'(busy), 0);
      ready_pct = 100;
      begin_scan(3, 40);
      wait_done("scan_after_rst", 300);

      // A start during SCAN with other bounds must be ignored.
      ready_pct = 60;
      begin_scan(0, 40);
      repeat (5) @(posedge clk);
      #1;
      lo    = W'(100);
      hi    = W'(120);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done("scan_ignore_start", 500);

      // Randomised bounds and consumer throttling.
      for (int it = 0; it < 8; it++) begin
         r_lo = $urandom_range(0, 255);
         r_hi = r_lo + $urandom_range(0, 40);
         if (r_hi > 255) r_hi = 255;
         ready_pct = $urandom_range(20, 100);
         begin_scan(r_lo, r_hi);
         wait_done($sformatf("rand_%0d", it), 2000);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
